fixed_point_requantizer: RTL

Streaming, pipelined converter between two signed fixed-point formats: a sample in N_IN.Q_IN (N integer bits including sign, Q fractional bits) becomes N_OUT.Q_OUT. Per-sample rounding mode, saturation on overflow, per-sample and sticky overflow flags. Sits between DSP stages whose Q formats differ (filters, mixers, DAC feed) and replaces software-side float/fixed conversion with synthesizable RTL.

---
 rtl/fixed_point_requantizer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fixed_point_requantizer.sv
// Two-stage streaming requantizer: signed N_IN.Q_IN -> N_OUT.Q_OUT with per-sample rounding and saturation.
// Define FIXED_POINT_REQUANTIZER_STATS_EN to add the saturated-transfer counter sts_overflow_count.
module fixed_point_requantizer #(
    parameter int N_IN  = 8,
    parameter int Q_IN  = 8,
    parameter int N_OUT = 4,
    parameter int Q_OUT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ing_valid,
    output logic                   ing_ready,
    input  logic [N_IN+Q_IN-1:0]   ing_data,
    input  logic [1:0]             ing_round_mode,
    output logic                   egr_valid,
    input  logic                   egr_ready,
    output logic [N_OUT+Q_OUT-1:0] egr_data,
    output logic                   egr_overflow,
    output logic                   sts_overflow_sticky,
    input  logic                   cmd_clear
`ifdef FIXED_POINT_REQUANTIZER_STATS_EN
    ,
    output logic [31:0]            sts_overflow_count
`endif
);

    localparam int WI   = N_IN + Q_IN;
    localparam int WO   = N_OUT + Q_OUT;
    localparam int D    = Q_IN - Q_OUT;
    localparam int GROW = (N_IN > N_OUT) ? (N_IN - N_OUT) : 0;
    // One spare bit so the rounding increment can never wrap.
    localparam int WM   = WO + GROW + 1;

    logic signed [WM-1:0] rounded;

    generate
        if (D > 0) begin : g_round
            localparam logic [D-1:0] HALF = D'(1) << (D - 1);
            logic signed [WI-D-1:0] shifted;
            logic [D-1:0]           dropped;
            logic                   inc;

            assign shifted = ing_data[WI-1:D];
            assign dropped = ing_data[D-1:0];

            always_comb begin
                inc = 1'b0;
                case (ing_round_mode)
                    2'd1:    inc = ing_data[WI-1] && (dropped != '0);
                    // Ties go up for positives and stay at floor for negatives: away from zero.
                    2'd2:    inc = ing_data[WI-1] ? (dropped > HALF) : (dropped >= HALF);
                    2'd3:    inc = (dropped > HALF) || ((dropped == HALF) && shifted[0]);
                    default: inc = 1'b0;
                endcase
            end

            assign rounded = WM'(shifted) + WM'(inc);
        end else begin : g_shift
            logic unused_mode;
            assign unused_mode = ^ing_round_mode;
            assign rounded     = WM'($signed(ing_data)) <<< (Q_OUT - Q_IN);
        end
    endgenerate

    logic          rdy_en_q, rdy_en_d;
    logic          s1_valid_q, s1_valid_d;
    logic [WM-1:0] s1_mid_q, s1_mid_d;
    logic          s2_valid_q, s2_valid_d;
    logic [WO-1:0] s2_data_q, s2_data_d;
    logic          s2_ovf_q, s2_ovf_d;
    logic          sticky_q, sticky_d;
    logic          s1_advance, s2_advance, ing_fire, egr_fire, in_range;
    logic [WO-1:0] sat_value;

    assign s2_advance = !s2_valid_q || egr_ready;
    assign s1_advance = !s1_valid_q || s2_advance;
    assign ing_ready  = rdy_en_q && s1_advance;
    assign ing_fire   = ing_valid && ing_ready;
    assign egr_fire   = s2_valid_q && egr_ready;

    // Value fits the output when every bit from the output sign upward agrees.
    assign in_range  = (&s1_mid_q[WM-1:WO-1]) || !(|s1_mid_q[WM-1:WO-1]);
    assign sat_value = s1_mid_q[WM-1] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};

    always_comb begin
        rdy_en_d   = 1'b1;
        s1_valid_d = s1_valid_q;
        s1_mid_d   = s1_mid_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_ovf_d   = s2_ovf_q;
        if (s1_advance) begin
            s1_valid_d = ing_fire;
            if (ing_fire) begin
                s1_mid_d = rounded;
            end
        end
        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = in_range ? s1_mid_q[WO-1:0] : sat_value;
                s2_ovf_d  = !in_range;
            end
        end
        sticky_d = (egr_fire && s2_ovf_q) || (sticky_q && !cmd_clear);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_mid_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_ovf_q   <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            rdy_en_q   <= rdy_en_d;
            s1_valid_q <= s1_valid_d;
            s1_mid_q   <= s1_mid_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_ovf_q   <= s2_ovf_d;
            sticky_q   <= sticky_d;
        end
    end

    assign egr_valid           = s2_valid_q;
    assign egr_data            = s2_data_q;
    assign egr_overflow        = s2_ovf_q;
    assign sts_overflow_sticky = sticky_q;

`ifdef FIXED_POINT_REQUANTIZER_STATS_EN
    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (cmd_clear) begin
            count_d = '0;
        end else if (egr_fire && s2_ovf_q && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign sts_overflow_count = count_q;
`endif

endmodule
